alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one alu_8bit instance between two requesters (e.g. pin-driven command path and an internal sequencer).
- Round-robin arbitration with valid/ready handshakes on both sides.
- Registers operands into the ALU, waits a programmable settle time, captures Result/Cout, and returns them to the granted requester.
- Sits between the top-level wrapper and alu_inst; the ALU itself stays purely combinational.

Parameters:
- SETTLE_CYC, 1, cycles operands are held on the ALU before capture (legal range 1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester command valid (bit i = requester i)
- req_ready  out  2  per-requester command accept
- req_a  in  16  operand A; [7:0] req0, [15:8] req1
- req_b  in  16  operand B; same packing
- req_sel  in  6  op select; [2:0] req0, [5:3] req1
- alu_a  out  8  to ALU .A, registered
- alu_b  out  8  to ALU .B, registered
- alu_sel  out  3  to ALU .sel, registered
- alu_result  in  8  from ALU .Result
- alu_cout  in  1  from ALU .Cout
- rsp_valid  out  2  per-requester response valid
- rsp_ready  in  2  per-requester response accept
- rsp_data  out  8  captured Result, shared by both requesters
- rsp_cout  out  1  captured Cout
- rsp_id  out  1  index of the requester owning the current response
- busy  out  1  high in any state other than IDLE
- op_count  out  8  completed operations, wraps 255->0

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; alu_a/alu_b/alu_sel=0; rsp_data=0; rsp_cout=0; rsp_id=0; op_count=0; settle counter=0.
  - last_grant=1, so requester 0 wins the first tie.
  - rsp_valid=0, req_ready=0, busy=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - grant g = the only valid requester; if both are valid, g = !last_grant.
  - req_ready[g]=1 combinationally while in IDLE with req_valid[g]=1; the other ready bit is 0.
  - On handshake: latch req_a/b/sel slice g into alu_a/b/sel, rsp_id<=g, last_grant<=g, settle counter<=SETTLE_CYC-1, go to ISSUE.
  - With no valid requester: stay in IDLE; ALU outputs hold their last values.
- ISSUE:
  - alu_* held stable; req_ready=0.
  - If the counter is 0: capture alu_result->rsp_data and alu_cout->rsp_cout, go to RESP. Otherwise decrement.
  - Residency is exactly SETTLE_CYC cycles.
- RESP:
  - rsp_valid[rsp_id]=1, the other bit 0; rsp_data, rsp_cout and rsp_id held stable.
  - On rsp_ready[rsp_id]=1: op_count+=1 (mod 256), go to IDLE.
  - rsp_ready of the non-owner is ignored.
  - Stalls indefinitely while rsp_ready is low.
- Latency (SETTLE_CYC=1, accept at edge T):
  - alu_* valid after T, rsp_valid high after T+1.
  - Earliest next accept at T+3; minimum 3 cycles per op.
- Requesters must hold req_* stable while valid and not ready; the block does not check this.
- Simultaneous events:
  - A requester asserting valid during ISSUE/RESP is not accepted until IDLE.
  - Arbitration uses last_grant updated at the previous accept.
- Reset mid-operation aborts immediately; the pending response is discarded (no rsp_valid after release).
- busy = (state != IDLE).

Test Plan:
- Single op: ALU stub returns A+B (carry to Cout). req0 sends A=0x05, B=0x03, sel=3'b010 -> req_ready[0] in the accept cycle, alu_sel=3'b010 next cycle, rsp_valid[0] two cycles after accept with rsp_data=0x08, rsp_cout=0, rsp_id=0; op_count=1 after rsp_ready.
- Carry: A=0xFF, B=0x01 -> rsp_data=0x00, rsp_cout=1.
- Tie and fairness: both valid continuously, 4 ops -> grant order 0,1,0,1; rsp_id matches; op_count=4.
- Backpressure and settle: SETTLE_CYC=3, rsp_ready held low 5 cycles -> rsp_valid stays high with data stable, busy=1, the other requester's req_ready=0 throughout; completes on ready.
- Wrap: 256 completed ops -> op_count returns to 0x00.
- Async reset asserted in ISSUE -> all outputs return to reset values without a clock edge; after release, req1-only valid is granted immediately and req0-only valid also works.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational 8-bit ALU between two requesters.
// Operands are registered onto the ALU and held for SETTLE_CYC cycles. The result is then captured.
module alu_share_arbiter #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [5:0]  req_sel,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_sel,
    input  logic [7:0]  alu_result,
    input  logic        alu_cout,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_cout,
    output logic        rsp_id,
    output logic        busy,
    output logic [7:0]  op_count
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e      state_q, state_d;
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
    logic [2:0]  alu_sel_q, alu_sel_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_cout_q, rsp_cout_d;
    logic        rsp_id_q, rsp_id_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  op_count_q, op_count_d;
    logic [3:0]  settle_q, settle_d;

    logic grant;
    logic accept;

    // A tie goes to whoever was not served at the previous accept.
    always_comb begin
        grant = 1'b0;
        unique case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant_q;
            default: grant = 1'b0;
        endcase
    end

    assign accept    = (state_q == StIdle) && (|req_valid);
    assign req_ready = accept ? {grant, ~grant} : 2'b00;

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_data_d   = rsp_data_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        op_count_d   = op_count_q;
        settle_d     = settle_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    alu_a_d      = grant ? req_a[15:8] : req_a[7:0];
                    alu_b_d      = grant ? req_b[15:8] : req_b[7:0];
                    alu_sel_d    = grant ? req_sel[5:3] : req_sel[2:0];
                    rsp_id_d     = grant;
                    last_grant_d = grant;
                    settle_d     = 4'(SETTLE_CYC - 1);
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                if (settle_q == 4'd0) begin
                    rsp_data_d = alu_result;
                    rsp_cout_d = alu_cout;
                    state_d    = StResp;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready[rsp_id_q]) begin
                    op_count_d = op_count_q + 8'd1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            alu_a_q      <= 8'd0;
            alu_b_q      <= 8'd0;
            alu_sel_q    <= 3'd0;
            rsp_data_q   <= 8'd0;
            rsp_cout_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            op_count_q   <= 8'd0;
            settle_q     <= 4'd0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_data_q   <= rsp_data_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
            op_count_q   <= op_count_d;
            settle_q     <= settle_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;
    assign busy      = (state_q != StIdle);
    assign rsp_valid = (state_q == StResp) ? {rsp_id_q, ~rsp_id_q} : 2'b00;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one instance with SETTLE_CYC=1 and one with SETTLE_CYC=3.
// Each instance drives an adder stub.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req_a, req_b;
    logic [5:0]  req_sel;

    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [7:0]  alu_a, alu_b, alu_result, rsp_data, op_count;
    logic [2:0]  alu_sel;
    logic        alu_cout, rsp_cout, rsp_id, busy;

    logic [1:0]  v3, ready3, rsp_valid3, rr3;
    logic [7:0]  alu_a3, alu_b3, alu_result3, rsp_data3, op_count3;
    logic [2:0]  alu_sel3;
    logic        alu_cout3, rsp_cout3, rsp_id3, busy3;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_cnt;

    always #5 clk = ~clk;

    assign {alu_cout, alu_result}   = {1'b0, alu_a} + {1'b0, alu_b};
    assign {alu_cout3, alu_result3} = {1'b0, alu_a3} + {1'b0, alu_b3};

    alu_share_arbiter #(.SETTLE_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_cout(rsp_cout), .rsp_id(rsp_id), .busy(busy), .op_count(op_count)
    );

    alu_share_arbiter #(.SETTLE_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(ready3),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3),
        .alu_result(alu_result3), .alu_cout(alu_cout3),
        .rsp_valid(rsp_valid3), .rsp_ready(rr3), .rsp_data(rsp_data3),
        .rsp_cout(rsp_cout3), .rsp_id(rsp_id3), .busy(busy3), .op_count(op_count3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_state();
        check("rst_busy", busy, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_sel", alu_sel, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_cout", rsp_cout, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_op_count", op_count, 0);
    endtask

    // One complete op on the SETTLE_CYC=1 instance with cycle-exact latency checks.
    task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] sel, input logic [7:0] ed, input logic ec);
        logic [1:0] mask;
        mask = id ? 2'b10 : 2'b01;
        @(negedge clk);
        req_a     = id ? {a, 8'h00} : {8'h00, a};
        req_b     = id ? {b, 8'h00} : {8'h00, b};
        req_sel   = id ? {sel, 3'b000} : {3'b000, sel};
        req_valid = mask;
        #1;
        check("op_req_ready", req_ready, mask);
        check("op_busy_idle", busy, 0);
        @(negedge clk);
        req_valid = 2'b00;
        check("op_alu_a", alu_a, a);
        check("op_alu_b", alu_b, b);
        check("op_alu_sel", alu_sel, sel);
        check("op_busy_issue", busy, 1);
        check("op_rsp_valid_issue", rsp_valid, 0);
        @(negedge clk);
        check("op_rsp_valid", rsp_valid, mask);
        check("op_rsp_data", rsp_data, ed);
        check("op_rsp_cout", rsp_cout, ec);
        check("op_rsp_id", rsp_id, id);
        rsp_ready = mask;
        @(negedge clk);
        rsp_ready = 2'b00;
        exp_cnt = exp_cnt + 8'd1;
        check("op_count", op_count, exp_cnt);
        check("op_busy_done", busy, 0);
    endtask

    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
        logic [7:0] exp_d;
        logic       exp_c;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int seen;
        int cycles;
        logic exp_id;

        vecs[0] = '{id: 1'b0, a: 8'h05, b: 8'h03, sel: 3'b010, exp_d: 8'h08, exp_c: 1'b0};
        vecs[1] = '{id: 1'b0, a: 8'hFF, b: 8'h01, sel: 3'b000, exp_d: 8'h00, exp_c: 1'b1};
        vecs[2] = '{id: 1'b1, a: 8'h80, b: 8'h80, sel: 3'b111, exp_d: 8'h00, exp_c: 1'b1};
        vecs[3] = '{id: 1'b1, a: 8'h12, b: 8'h34, sel: 3'b101, exp_d: 8'h46, exp_c: 1'b0};
        vecs[4] = '{id: 1'b0, a: 8'hC0, b: 8'h50, sel: 3'b001, exp_d: 8'h10, exp_c: 1'b1};

        rst_n = 1'b0;
        req_valid = 0; rsp_ready = 0; v3 = 0; rr3 = 0;
        req_a = 0; req_b = 0; req_sel = 0;
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        check_reset_state();
        check("rst_busy3", busy3, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sel,
                                 vecs[i].exp_d, vecs[i].exp_c);

        // Fairness: both valid continuously after reset -> 0,1,0,1.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        req_a = {8'h20, 8'h10}; req_b = {8'h02, 8'h01}; req_sel = {3'b101, 3'b011};
        req_valid = 2'b11; rsp_ready = 2'b11;
        seen = 0; cycles = 0; exp_id = 1'b0;
        while (seen < 4 && cycles < 30) begin
            @(negedge clk);
            cycles++;
            if (rsp_valid != 2'b00) begin
                check("fair_rsp_id", rsp_id, exp_id);
                check("fair_rsp_valid", rsp_valid, exp_id ? 2'b10 : 2'b01);
                check("fair_rsp_data", rsp_data, exp_id ? 8'h22 : 8'h11);
                exp_id = ~exp_id;
                seen++;
                if (seen == 4) req_valid = 2'b00;
            end
        end
        check("fair_resp_seen", seen, 4);
        @(negedge clk);
        rsp_ready = 2'b00;
        check("fair_op_count", op_count, 4);

        // Wrap: 256 back-to-back ops from requester 0 after reset.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b01; rsp_ready = 2'b11;
        seen = 0; cycles = 0;
        while (seen < 256 && cycles < 1000) begin
            @(negedge clk);
            cycles++;
            if (rsp_valid != 2'b00) begin
                seen++;
                if (seen == 256) begin
                    check("wrap_pre_count", op_count, 8'hFF);
                    req_valid = 2'b00;
                end
            end
        end
        check("wrap_resp_seen", seen, 256);
        @(negedge clk);
        rsp_ready = 2'b00;
        check("wrap_op_count", op_count, 8'h00);

        // Backpressure on SETTLE_CYC=3 instance with requester 1 waiting.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_a = {8'h77, 8'h05}; req_b = {8'h11, 8'h03}; req_sel = {3'b110, 3'b010};
        v3 = 2'b11;
        #1;
        check("bp_ready_accept", ready3, 2'b01);
        @(negedge clk);
        v3 = 2'b10;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_settle_no_rsp", rsp_valid3, 0);
            check("bp_settle_busy", busy3, 1);
            check("bp_settle_ready", ready3, 0);
        end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", rsp_valid3, 2'b01);
            check("bp_rsp_data", rsp_data3, 8'h08);
            check("bp_busy", busy3, 1);
            check("bp_other_ready", ready3, 0);
            rr3 = 2'b10;
            @(negedge clk);
        end
        check("bp_still_valid", rsp_valid3, 2'b01);
        rr3 = 2'b01;
        @(negedge clk);
        rr3 = 2'b00;
        check("bp_op_count", op_count3, 1);
        #1;
        check("bp_next_ready", ready3, 2'b10);
        v3 = 2'b00;

        // Async reset during ISSUE, then each requester alone.
        @(negedge clk);
        exp_cnt = 0;
        req_a = {8'h00, 8'h33}; req_b = {8'h00, 8'h44}; req_sel = {3'b000, 3'b011};
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        check("ar_in_issue", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("ar_no_rsp", rsp_valid, 0);
        end
        run_op(1'b1, 8'h0A, 8'h0B, 3'b100, 8'h15, 1'b0);
        run_op(1'b0, 8'hF0, 8'h20, 3'b001, 8'h10, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
